i2c_req_arbiter: RTL and testbench
==================================

I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 20000: cycles allowed in WAIT before abort (used only when I2C_ARB_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req  input  4  per-requester level request, held until ack.
REQ-005 SHALL have port req_addr  input  28  packed 7-bit slave addresses; requester i at [7i+6:7i].
REQ-006 SHALL have port req_data  input  32  packed write bytes; requester i at [8i+7:8i].
REQ-007 SHALL have port ack  output  4  one-cycle completion pulse to the served requester.
REQ-008 SHALL have port err  output  4  one-cycle timeout flag, coincident with ack.
REQ-009 SHALL have port m_start  output  1  one-cycle start pulse to i2c_master.
REQ-010 SHALL have port m_slave_addr  output  7  address to i2c_master, stable from m_start to completion.
REQ-011 SHALL have port m_data  output  8  data byte to i2c_master, stable from m_start to completion.
REQ-012 SHALL have port m_busy  input  1  i2c_master busy.
REQ-013 SHALL have port m_done  input  1  i2c_master completion pulse.
REQ-014 SHALL have port arb_busy  output  1  high from grant until the ack cycle inclusive.
REQ-015 SHALL have port grant_id  output  2  index of current owner; valid while arb_busy.

Function
REQ-016 SHALL implement FSM IDLE -> LAUNCH -> WAIT -> RELEASE -> IDLE.
REQ-017 IDLE: on any req bit high, SHALL grant round-robin (search from last_grant+1 mod 4), latch owner addr/data into m_slave_addr/m_data, set grant_id, arb_busy=1, go LAUNCH.
REQ-018 LAUNCH: SHALL drive m_start=1 for exactly this one cycle, then go WAIT.
REQ-019 WAIT: SHALL go RELEASE in the cycle after m_done is sampled high; m_busy is status only and does not drive transitions.
REQ-020 RELEASE: SHALL pulse ack[grant_id] for one cycle, update last_grant=grant_id, go IDLE; arb_busy falls the next cycle.
REQ-021 Latency SHALL be: req seen in IDLE at cycle N -> m_start at N+1; m_done at cycle M -> ack at M+1; earliest next m_start at M+3.
REQ-022 Req/addr/data changes after grant SHALL be ignored until RELEASE; a dropped req still completes and is acked.
REQ-023 m_done sampled outside WAIT SHALL be ignored.
REQ-024 A req still high in the IDLE cycle after its ack SHALL count as a new request at round-robin priority.
REQ-025 All four requesting simultaneously SHALL each be served exactly once before any repeat.
REQ-026 At most one ack bit SHALL be high in any cycle; err SHALL be zero whenever ack is zero.

Reset
REQ-027 On rst high, SHALL immediately enter IDLE, asynchronously, including mid-transaction: m_start=0, m_slave_addr=0, m_data=0, ack=0, err=0, arb_busy=0, grant_id=0, last_grant=3 (so requester 0 wins first), timeout counter=0.
REQ-028 After rst deasserts, SHALL issue no ack for any transaction interrupted by the reset.

Configuration
REQ-029 With I2C_ARB_TIMEOUT_EN defined: WAIT SHALL count cycles from 0; on reaching TIMEOUT_CYCLES without m_done, SHALL go RELEASE and pulse both ack and err for the owner. The counter SHALL clear on entry to WAIT.
REQ-030 Without I2C_ARB_TIMEOUT_EN: WAIT SHALL wait indefinitely for m_done; err SHALL be tied 0 and no counter logic SHALL exist.

Verification
REQ-031 Single: req=0001, addr0=7'h50, data0=8'hAC -> m_start one cycle later with m_slave_addr=7'h50, m_data=8'hAC; m_done -> ack=0001 next cycle.
REQ-032 Contention: req=1111 held -> grant order 0,1,2,3,0; each ack one-hot; no overlap of m_start with WAIT.
REQ-033 Retract: requester 2 drops req and changes data after grant -> original byte stays on m_data; ack=0100 still pulses.
REQ-034 Reset mid-WAIT: rst high for 2 cycles -> all outputs 0 at once; no ack after release; next grant goes to requester 0.
REQ-035 Timeout (macro on, TIMEOUT_CYCLES=16): m_done never asserted -> ack and err pulse together for the owner 16 cycles after WAIT entry; macro off -> arb_busy stays high.
REQ-036 Spurious m_done in IDLE and in LAUNCH -> no state change, no ack.

Source files
------------

// File: rtl/i2c_req_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the downstream i2c_master.
// slave = arbiter view, master = requester/i2c_master (environment) view.
interface i2c_req_arbiter_if;
    logic [3:0]  req;
    logic [27:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic        m_start;
    logic [6:0]  m_slave_addr;
    logic [7:0]  m_data;
    logic        m_busy;
    logic        m_done;
    logic        arb_busy;
    logic [1:0]  grant_id;

    modport slave (
        input  req, req_addr, req_data, m_busy, m_done,
        output ack, err, m_start, m_slave_addr, m_data, arb_busy, grant_id
    );

    modport master (
        output req, req_addr, req_data, m_busy, m_done,
        input  ack, err, m_start, m_slave_addr, m_data, arb_busy, grant_id
    );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter multiplexing four requesters onto one i2c_master.
// Optional WAIT timeout abort enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_req_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input logic             clk,
    input logic             rst,
    i2c_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [1:0]  last_grant;
    logic [1:0]  grant_id;
    logic [1:0]  pick;
    logic [6:0]  slave_addr;
    logic [7:0]  data;
    logic [3:0]  ack_vec;
    logic        timeout_hit;
    logic        unused;

    assign unused = bus.m_busy ^ (TIMEOUT_CYCLES == 0);

    // First requester at or after last_grant+1, wrapping modulo 4.
    always_comb begin
        logic [1:0] cand;
        logic       found;
        pick  = last_grant + 2'd1;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last_grant + 2'(i);
            if (!found && bus.req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ack_vec    = '0;
        case (state)
            S_IDLE:    if (|bus.req) next_state = S_LAUNCH;
            S_LAUNCH:  next_state = S_WAIT;
            S_WAIT:    if (bus.m_done || timeout_hit) next_state = S_RELEASE;
            S_RELEASE: begin
                next_state = S_IDLE;
                ack_vec    = 4'b0001 << grant_id;
            end
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id   <= '0;
            last_grant <= 2'd3;
            slave_addr <= '0;
            data       <= '0;
        end else begin
            if (state == S_IDLE && |bus.req) begin
                grant_id   <= pick;
                slave_addr <= bus.req_addr[7*pick +: 7];
                data       <= bus.req_data[8*pick +: 8];
            end
            if (state == S_RELEASE) begin
                last_grant <= grant_id;
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;
    logic          timed_out;

    // Counter holds k in the k-th WAIT cycle; abort fires after TIMEOUT_CYCLES cycles.
    assign timeout_hit = (state == S_WAIT) && !bus.m_done &&
                         (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
        end else begin
            if (state == S_LAUNCH) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == S_WAIT) begin
                timed_out <= timeout_hit;
            end
        end
    end

    assign bus.err = timed_out ? ack_vec : '0;
`else
    assign timeout_hit = 1'b0;
    assign bus.err     = '0;
`endif

    assign bus.ack          = ack_vec;
    assign bus.m_start      = (state == S_LAUNCH);
    assign bus.arb_busy     = (state != S_IDLE);
    assign bus.grant_id     = grant_id;
    assign bus.m_slave_addr = slave_addr;
    assign bus.m_data       = data;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomised and directed bench for i2c_req_arbiter against a round-robin model.
// Works with and without I2C_ARB_TIMEOUT_EN defined.
module tb_i2c_req_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   model_last;
    int   got;
    int   o;

    always #5 clk = ~clk;

    i2c_req_arbiter_if bus();

    i2c_req_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next owner: first set request bit scanning upward from last+1, modulo 4.
    function automatic int pick_model(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_m_start"},  32'(bus.m_start), 0);
        check({tag, "_addr"},     32'(bus.m_slave_addr), 0);
        check({tag, "_data"},     32'(bus.m_data), 0);
        check({tag, "_ack"},      32'(bus.ack), 0);
        check({tag, "_err"},      32'(bus.err), 0);
        check({tag, "_arb_busy"}, 32'(bus.arb_busy), 0);
        check({tag, "_grant_id"}, 32'(bus.grant_id), 0);
    endtask

    // Called in an IDLE cycle with req already driven; returns in the following IDLE cycle.
    task automatic serve(input int delay, input bit keep, input bit retract, input bit spur,
                         output int owner);
        int          e;
        logic [6:0]  ea;
        logic [7:0]  ed;
        e  = pick_model(model_last, bus.req);
        ea = bus.req_addr[7*e +: 7];
        ed = bus.req_data[8*e +: 8];
        if (spur) bus.m_done = 1'b1;
        tick();
        owner = int'(bus.grant_id);
        check("launch_m_start",  32'(bus.m_start), 1);
        check("launch_grant_id", 32'(bus.grant_id), 32'(e));
        check("launch_addr",     32'(bus.m_slave_addr), 32'(ea));
        check("launch_data",     32'(bus.m_data), 32'(ed));
        check("launch_busy",     32'(bus.arb_busy), 1);
        check("launch_ack",      32'(bus.ack), 0);
        tick();
        if (spur) bus.m_done = 1'b0;
        check("wait_m_start", 32'(bus.m_start), 0);
        for (int d = 0; d < delay; d++) begin
            if (retract && d == 0) begin
                bus.req[e]              = 1'b0;
                bus.req_data[8*e +: 8]  = ~ed;
                bus.req_addr[7*e +: 7]  = ~ea;
            end
            if ($urandom_range(0, 3) == 0) bus.req = bus.req | 4'(1 << $urandom_range(0, 3));
            tick();
            check("wait_addr_hold", 32'(bus.m_slave_addr), 32'(ea));
            check("wait_data_hold", 32'(bus.m_data), 32'(ed));
            check("wait_ack",       32'(bus.ack), 0);
            check("wait_busy",      32'(bus.arb_busy), 1);
        end
        bus.m_done = 1'b1;
        tick();
        bus.m_done = 1'b0;
        check("release_ack",  32'(bus.ack), 32'(1) << e);
        check("release_err",  32'(bus.err), 0);
        check("release_busy", 32'(bus.arb_busy), 1);
        if (!keep) bus.req[e] = 1'b0;
        model_last = e;
        tick();
        check("idle_busy", 32'(bus.arb_busy), 0);
        check("idle_ack",  32'(bus.ack), 0);
    endtask

    initial begin
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.m_done   = 1'b0;
        bus.m_busy   = 1'b0;
        model_last   = 3;
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Spurious m_done while idle
        bus.m_done = 1'b1;
        tick();
        tick();
        bus.m_done = 1'b0;
        check("spur_idle_ack",  32'(bus.ack), 0);
        check("spur_idle_busy", 32'(bus.arb_busy), 0);

        // Single request
        bus.req              = 4'b0001;
        bus.req_addr[6:0]    = 7'h50;
        bus.req_data[7:0]    = 8'hAC;
        serve(2, 1'b0, 1'b0, 1'b0, got);
        check("single_owner", 32'(got), 0);

        // Spurious m_done in IDLE and LAUNCH of a real transaction
        bus.req             = 4'b0010;
        bus.req_addr[13:7]  = 7'h2B;
        bus.req_data[15:8]  = 8'h5A;
        serve(3, 1'b0, 1'b0, 1'b1, got);

        // Requester 2 retracts and changes its byte after grant
        bus.req             = 4'b0100;
        bus.req_addr[20:14] = 7'h33;
        bus.req_data[23:16] = 8'hC3;
        serve(3, 1'b0, 1'b1, 1'b0, got);
        check("retract_owner", 32'(got), 2);

        // Reset mid-WAIT
        bus.req = 4'b0110;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_async");
        bus.req = '0;
        tick();
        tick();
        check_idle_outputs("rst_held");
        rst        = 1'b0;
        model_last = 3;
        bus.m_done = 1'b1;
        tick();
        bus.m_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_ack", 32'(bus.ack), 0);
        end

        // Full contention, held requests
        bus.req      = 4'b1111;
        bus.req_addr = 28'($urandom);
        bus.req_data = $urandom;
        for (int i = 0; i < 5; i++) begin
            serve(1 + i, 1'b1, 1'b0, 1'b0, got);
            check("contention_order", 32'(got), 32'(exp_order[i]));
        end
        bus.req = '0;
        tick();

        // m_done never arrives
        bus.req = 4'b1000;
        o = pick_model(model_last, bus.req);
        tick();
        tick();
`ifdef I2C_ARB_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            tick();
            check("timeout_pending_ack", 32'(bus.ack), 0);
        end
        tick();
        check("timeout_ack", 32'(bus.ack), 32'(1) << o);
        check("timeout_err", 32'(bus.err), 32'(1) << o);
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            check("no_timeout_busy", 32'(bus.arb_busy), 1);
            check("no_timeout_ack",  32'(bus.ack), 0);
        end
        bus.m_done = 1'b1;
        tick();
        bus.m_done = 1'b0;
        check("late_done_ack", 32'(bus.ack), 32'(1) << o);
`endif
        bus.req    = '0;
        model_last = o;
        tick();
        check("timeout_idle", 32'(bus.arb_busy), 0);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            if (bus.req == '0) begin
                bus.req      = 4'($urandom_range(1, 15));
                bus.req_addr = 28'($urandom);
                bus.req_data = $urandom;
            end
            serve(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
